// File: rtl/rc_share_arb_pkg.sv
// rc_share_arb_pkg: shared constants, coordinate slices, port encoding, FSM state and pointer helper
package rc_share_arb_pkg;
  localparam int RC_NUM_PORT = 5;
  localparam int RC_DST_WIDTH = 6;
  localparam int RC_DIR_WIDTH = 2;
  localparam int IDX_W = 3;
  localparam int COORD_W = 3;
  localparam int X_LSB = 0;
  localparam int Y_LSB = 3;
  typedef enum logic [IDX_W-1:0] {P_N = 3'd0, P_E = 3'd1, P_S = 3'd2, P_W = 3'd3, P_L = 3'd4} port_e;
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i, input int n);
    return (int'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/rc_share_arb_if.sv
// rc_share_arb_if: request/route-compute/response bundle; master = requesters+rc unit+consumer, slave = arbiter
interface rc_share_arb_if
  import rc_share_arb_pkg::*;
#(
  parameter int NUM_PORT = RC_NUM_PORT,
  parameter int DST_WIDTH = RC_DST_WIDTH,
  parameter int DIR_WIDTH = RC_DIR_WIDTH
);
  logic [NUM_PORT-1:0] req_valid;
  logic [NUM_PORT*DST_WIDTH-1:0] req_dst;
  logic [NUM_PORT*DIR_WIDTH-1:0] req_outdir;
  logic [NUM_PORT-1:0] req_ready;
  logic [DST_WIDTH-1:0] rc_dst;
  logic [DIR_WIDTH-1:0] rc_outdir;
  logic [NUM_PORT-1:0] rc_ppv;
  logic resp_valid;
  logic [IDX_W-1:0] resp_port;
  logic [NUM_PORT-1:0] resp_ppv;
  logic resp_err;
  logic resp_ready;
  modport master (
    output req_valid, req_dst, req_outdir, rc_ppv, resp_ready,
    input req_ready, rc_dst, rc_outdir, resp_valid, resp_port, resp_ppv, resp_err
  );
  modport slave (
    input req_valid, req_dst, req_outdir, rc_ppv, resp_ready,
    output req_ready, rc_dst, rc_outdir, resp_valid, resp_port, resp_ppv, resp_err
  );
endinterface

// File: rtl/rc_share_arb_rr_pick.sv
// rr_pick: round-robin selector; ports req/ptr in, one-hot gnt, gnt index idx and any-request flag out
module rr_pick
  import rc_share_arb_pkg::*;
#(
  parameter int N = RC_NUM_PORT
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx = IDX_W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rc_share_arb.sv
// rc_share_arb: round-robin share of one route-compute unit; ports clk, reset, bus (slave), stall_cnt; optional RC_ARB_STALL_CNT_EN
module rc_share_arb
  import rc_share_arb_pkg::*;
#(
  parameter int NUM_PORT = RC_NUM_PORT,
  parameter int DST_WIDTH = RC_DST_WIDTH,
  parameter int DIR_WIDTH = RC_DIR_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  rc_share_arb_if.slave  bus,
  output logic [15:0]    stall_cnt
);
  state_e state, state_d;
  logic [IDX_W-1:0] rr_ptr, idx, sel;
  logic [NUM_PORT-1:0] gnt, req_m;
  logic any, can_grant;
  assign can_grant = !reset && (state == EMPTY || bus.resp_ready);
  assign req_m = bus.req_valid & {NUM_PORT{can_grant}};
  rr_pick #(.N(NUM_PORT)) u_pick (.req(req_m), .ptr(rr_ptr), .gnt(gnt), .idx(idx), .any(any));
  assign bus.req_ready = gnt;
  assign bus.resp_valid = (state == FULL);
  assign sel = any ? idx : rr_ptr;
  always_comb begin
    bus.rc_dst = '0;
    bus.rc_outdir = '0;
    for (int i = 0; i < NUM_PORT; i++) begin
      if (int'(sel) == i) begin
        bus.rc_dst = bus.req_dst[i*DST_WIDTH +: DST_WIDTH];
        bus.rc_outdir = bus.req_outdir[i*DIR_WIDTH +: DIR_WIDTH];
      end
    end
  end
  always_comb state_d = any ? FULL : (state == FULL && bus.resp_ready) ? EMPTY : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      rr_ptr <= '0;
      bus.resp_port <= '0;
      bus.resp_ppv <= '0;
      bus.resp_err <= 1'b0;
    end else begin
      state <= state_d;
      if (any) begin
        bus.resp_port <= idx;
        bus.resp_ppv <= bus.rc_ppv;
        bus.resp_err <= ~|bus.rc_ppv;
        rr_ptr <= wrap_inc(idx, NUM_PORT);
      end
    end
  end
`ifdef RC_ARB_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) stall_cnt <= '0;
    else if (bus.resp_valid && !bus.resp_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_rc_share_arb.sv
// tb_rc_share_arb: directed self-checking bench for rc_share_arb
module tb_rc_share_arb;
  import rc_share_arb_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] stall_cnt;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  rc_share_arb_if bus ();
  rc_share_arb dut (.clk(clk), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_p[6];
    exp_p = '{0, 1, 2, 3, 4, 0};
    bus.req_valid = 5'b11111;
    for (int i = 0; i < RC_NUM_PORT; i++) begin
      bus.req_dst[i*RC_DST_WIDTH +: RC_DST_WIDTH] = 6'(i * 9 + 1);
      bus.req_outdir[i*RC_DIR_WIDTH +: RC_DIR_WIDTH] = 2'(i);
    end
    bus.rc_ppv = 5'b00001;
    bus.resp_ready = 1'b0;
    #1;
    check("rst_ready0", 32'(bus.req_ready), 32'h0);
    tick;
    check("rst_ready1", 32'(bus.req_ready), 32'h0);
    tick;
    check("rst_ready2", 32'(bus.req_ready), 32'h0);
    check("rst_valid", 32'(bus.resp_valid), 32'h0);
    check("rst_port", 32'(bus.resp_port), 32'h0);
    check("rst_stall", 32'(stall_cnt), 32'h0);
    reset = 1'b0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("rot_gnt", 32'(bus.req_ready), 32'(1 << exp_p[k]));
      check("rot_dst", 32'(bus.rc_dst), 32'(exp_p[k] * 9 + 1));
      check("rot_dir", 32'(bus.rc_outdir), 32'(exp_p[k] % 4));
      tick;
      check("rot_valid", 32'(bus.resp_valid), 32'h1);
      check("rot_port", 32'(bus.resp_port), 32'(exp_p[k]));
    end
    bus.req_valid = 5'b00100;
    #1;
    check("bp_gnt", 32'(bus.req_ready), 32'h04);
    tick;
    check("bp_port0", 32'(bus.resp_port), 32'h2);
    bus.resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      tick;
      check("bp_valid", 32'(bus.resp_valid), 32'h1);
      check("bp_port", 32'(bus.resp_port), 32'h2);
    end
`ifdef RC_ARB_STALL_CNT_EN
    check("bp_stall", 32'(stall_cnt), 32'h4);
`else
    check("bp_stall", 32'(stall_cnt), 32'h0);
`endif
    bus.resp_ready = 1'b1;
    bus.req_valid = 5'b01000;
    #1;
    check("wr_gnt3", 32'(bus.req_ready), 32'h08);
    tick;
    check("wr_port3", 32'(bus.resp_port), 32'h3);
    bus.req_valid = 5'b10001;
    #1;
    check("wr_gnt4", 32'(bus.req_ready), 32'h10);
    tick;
    check("wr_port4", 32'(bus.resp_port), 32'h4);
    #1;
    check("wr_gnt0", 32'(bus.req_ready), 32'h01);
    tick;
    check("wr_port0", 32'(bus.resp_port), 32'h0);
    bus.req_valid = 5'b00010;
    bus.rc_ppv = 5'b00000;
    #1;
    check("err_gnt", 32'(bus.req_ready), 32'h02);
    tick;
    check("err_set", 32'(bus.resp_err), 32'h1);
    check("err_ppv", 32'(bus.resp_ppv), 32'h0);
    bus.req_valid = 5'b00100;
    bus.rc_ppv = 5'b10000;
    #1;
    check("ok_gnt", 32'(bus.req_ready), 32'h04);
    tick;
    check("ok_err", 32'(bus.resp_err), 32'h0);
    check("ok_ppv", 32'(bus.resp_ppv), 32'h10);
    check("ok_port", 32'(bus.resp_port), 32'h2);
    bus.resp_ready = 1'b0;
    bus.req_valid = 5'b01010;
    #1;
    check("mr_full_ready", 32'(bus.req_ready), 32'h0);
    tick;
    reset = 1'b1;
    #1;
    check("mr_ready", 32'(bus.req_ready), 32'h0);
    tick;
    check("mr_valid", 32'(bus.resp_valid), 32'h0);
    check("mr_port", 32'(bus.resp_port), 32'h0);
    check("mr_stall", 32'(stall_cnt), 32'h0);
    reset = 1'b0;
    #1;
    check("mr_gnt", 32'(bus.req_ready), 32'h02);
    tick;
    check("mr_valid1", 32'(bus.resp_valid), 32'h1);
    check("mr_port1", 32'(bus.resp_port), 32'h1);
    bus.resp_ready = 1'b1;
    bus.req_valid = 5'b00000;
    #1;
    check("dr_ready", 32'(bus.req_ready), 32'h0);
    tick;
    check("dr_valid", 32'(bus.resp_valid), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rc_share_arb.md
RC_SHARE_ARB -- requirements
Module: rc_share_arb

Interface
REQ-001 SHALL have parameter NUM_PORT, default 5, number of requesting input ports (N,E,S,W,Local).
REQ-002 SHALL have parameter DST_WIDTH, default 6, destination field width ({Y[2:0],X[2:0]}).
REQ-003 SHALL have parameter DIR_WIDTH, default 2, outdir field width per requester.
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req_valid  input  NUM_PORT  per-port route-compute request.
REQ-007 SHALL have port req_dst  input  NUM_PORT*DST_WIDTH  per-port destination, port i at slice i.
REQ-008 SHALL have port req_outdir  input  NUM_PORT*DIR_WIDTH  per-port outdir, port i at slice i.
REQ-009 SHALL have port req_ready  output  NUM_PORT  one-hot grant; request consumed when req_valid[i]&req_ready[i].
REQ-010 SHALL have port rc_dst  output  DST_WIDTH  dst driven to shared route-compute unit.
REQ-011 SHALL have port rc_outdir  output  DIR_WIDTH  outdir driven to shared route-compute unit.
REQ-012 SHALL have port rc_ppv  input  NUM_PORT  prefer-port vector returned combinationally by route-compute unit.
REQ-013 SHALL have port resp_valid  output  1  result register holds a result.
REQ-014 SHALL have port resp_port  output  3  index of requester owning result.
REQ-015 SHALL have port resp_ppv  output  NUM_PORT  registered prefer-port vector.
REQ-016 SHALL have port resp_err  output  1  registered rc_ppv was all-zero.
REQ-017 SHALL have port resp_ready  input  1  consumer accepts result when resp_valid&resp_ready.
REQ-018 SHALL have port stall_cnt  output  16  result-stall counter (see Configuration).

Function
REQ-019 SHALL implement two states: EMPTY (no result held) and FULL (result held, resp_valid=1).
REQ-020 SHALL grant (can_grant=1) when state EMPTY, or state FULL and resp_ready=1 in the same cycle.
REQ-021 SHALL, when can_grant and any req_valid, assert exactly one req_ready bit: first requesting port at or after rr_ptr, scanning upward modulo NUM_PORT.
REQ-022 SHALL hold req_ready all-zero when can_grant=0 or no req_valid.
REQ-023 SHALL drive rc_dst/rc_outdir combinationally from the granted port; from port rr_ptr when no grant.
REQ-024 SHALL, on grant, capture rc_ppv into resp_ppv, grantee index into resp_port, (rc_ppv==0) into resp_err, enter FULL at next edge; latency request-to-resp_valid is exactly 1 cycle.
REQ-025 SHALL, on grant, set rr_ptr to grantee+1, wrapping NUM_PORT-1 to 0; rr_ptr unchanged otherwise.
REQ-026 SHALL, in FULL with resp_ready=1 and no grant, return to EMPTY; with simultaneous grant remain FULL with new contents (back-to-back, 1 result/cycle).
REQ-027 SHALL hold resp_port/resp_ppv/resp_err stable while FULL and resp_ready=0.
REQ-028 SHALL ignore req_dst/req_outdir of non-granted ports; a request held without grant is not lost.

Reset
REQ-029 SHALL, with reset=1 at a clock edge, set state EMPTY, rr_ptr=0, resp_valid=0, resp_port=0, resp_ppv=0, resp_err=0, stall_cnt=0.
REQ-030 SHALL force req_ready=0 during any cycle with reset=1; a held result is discarded by mid-operation reset.

Configuration
REQ-031 SHALL, with RC_ARB_STALL_CNT_EN defined, increment stall_cnt each cycle resp_valid=1 and resp_ready=0, saturating at 16'hFFFF, cleared only by reset.
REQ-032 SHALL, without RC_ARB_STALL_CNT_EN, tie stall_cnt to 16'd0 and instantiate no counter logic.

Structure
REQ-033 SHALL take NUM_PORT, DST_WIDTH, coordinate field slices and port-index encoding (0=N,1=E,2=S,3=W,4=Local) from the shared global header.
REQ-034 SHALL place the round-robin selector in sub-module rr_pick (inputs req vector, rr_ptr; outputs one-hot grant, index, any).
REQ-035 SHALL NOT instantiate the route-compute unit; it is external and wired via rc_*.

Verification
REQ-036 Reset: reset=1 two cycles with req_valid=5'b11111 -> req_ready=0, resp_valid=0, stall_cnt=0.
REQ-037 Rotation: req_valid=5'b11111 held, resp_ready=1 -> grants ports 0,1,2,3,4,0 on consecutive cycles, resp_port trails by 1 cycle.
REQ-038 Backpressure: single grant port 2, resp_ready=0 for 4 cycles -> resp_valid held, resp_port=2 stable, req_ready=0, stall_cnt=4 (macro on) / 0 (off).
REQ-039 Wrap: rr_ptr=4 after grant to port 3, req_valid=5'b10001 -> grant port 4, then port 0.
REQ-040 Error: rc_ppv=5'b00000 on grant -> resp_err=1 next cycle; rc_ppv=5'b10000 -> resp_ppv=5'b10000, resp_err=0.
REQ-041 Mid-reset: reset asserted while FULL -> next cycle resp_valid=0, rr_ptr=0, first grant after release goes to lowest requesting port.
